// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS32 register file slice.
//   REG_ZERO / REG_SP / REG_RA : architectural register indices
//   SP_RESET                   : stack-pointer value loaded on reset
//   DATA_W_DEF / ADDR_W_DEF    : default register width / index width
package regfile_pkg;
  localparam int          DATA_W_DEF = 32;
  localparam int          ADDR_W_DEF = 5;
  localparam int          REG_ZERO   = 0;
  localparam int          REG_SP     = 29;
  localparam int          REG_RA     = 31;
  localparam logic [31:0] SP_RESET   = 32'h100;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard used by the hazard unit.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   we0/wa0, we1/wa1     : writeback enables/addresses (clear busy)
//   claim_en/claim_addr  : decode claim of a destination (set busy)
//   ra                   : packed read addresses, NREAD x ADDR_W
//   rbusy                : registered busy bit per read port
import regfile_pkg::*;

module regfile_scoreboard #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we0,
  input  logic [ADDR_W-1:0]         wa0,
  input  logic                      we1,
  input  logic [ADDR_W-1:0]         wa1,
  input  logic                      claim_en,
  input  logic [ADDR_W-1:0]         claim_addr,
  input  logic [NREAD*ADDR_W-1:0]   ra,
  output logic [NREAD-1:0]          rbusy
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;

  // A claim beats a same-cycle write: the claiming instruction is the
  // newer producer, so the register stays busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < DEPTH; r++) begin
      if (claim_en && (claim_addr == ADDR_W'(r)))
        busy_d[r] = 1'b1;
      else if ((we0 && (wa0 == ADDR_W'(r))) || (we1 && (wa1 == ADDR_W'(r))))
        busy_d[r] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NREAD; i++)
      rbusy[i] = busy_q[ra[i*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS32 register file: NREAD combinational read ports, two
// synchronous write ports (port 1 wins on collision), r0 hardwired to zero,
// SP_IDX reset to SP_INIT, plus the busy scoreboard.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write data onto
// the read ports; otherwise writes are visible one cycle later.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   we0/wa0/wd0         : write port 0 (ALU writeback)
//   we1/wa1/wd1         : write port 1 (load / MULDIV writeback)
//   claim_en/claim_addr : mark destination busy
//   ra / rd / rbusy     : packed read addresses, data, busy flags
import regfile_pkg::*;

module regfile_mp #(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter int                NREAD   = 3,
  parameter int                SP_IDX  = REG_SP,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_RESET)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic [NREAD*ADDR_W-1:0]  ra,
  output logic [NREAD*DATA_W-1:0]  rd,
  output logic [NREAD-1:0]         rbusy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] rf_q [DEPTH];

  // Port 1 is assigned last so it wins when both ports hit one address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++)
        rf_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
    end else begin
      if (we0 && (wa0 != ZERO_A)) rf_q[wa0] <= wd0;
      if (we1 && (wa1 != ZERO_A)) rf_q[wa1] <= wd1;
    end
  end

  logic [ADDR_W-1:0] rd_a [NREAD];
  logic [DATA_W-1:0] rd_v [NREAD];

  always_comb begin
    rd = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_a[i] = ra[i*ADDR_W +: ADDR_W];
      rd_v[i] = (rd_a[i] == ZERO_A) ? '0 : rf_q[rd_a[i]];
`ifdef REGFILE_BYPASS_EN
      if (rd_a[i] != ZERO_A) begin
        if (we1 && (wa1 == rd_a[i]))      rd_v[i] = wd1;
        else if (we0 && (wa0 == rd_a[i])) rd_v[i] = wd0;
      end
`endif
      rd[i*DATA_W +: DATA_W] = rd_v[i];
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .we0        (we0),
    .wa0        (wa0),
    .we1        (we1),
    .wa1        (wa1),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .ra         (ra),
    .rbusy      (rbusy)
  );
endmodule
